// File: rtl/cpu_pkg.sv
// Shared encodings for the instruction-sequencing controller: states, opcodes,
// register-number and write-back selects, and the legality check.
package cpu_pkg;

    typedef enum logic [2:0] {
        StWait,
        StDecode,
        StWriteImm,
        StGetA,
        StGetB,
        StAlu,
        StWriteReg
    } state_t;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [2:0] NSEL_NONE = 3'b000;
    localparam logic [2:0] NSEL_RN   = 3'b001;
    localparam logic [2:0] NSEL_RD   = 3'b010;
    localparam logic [2:0] NSEL_RM   = 3'b100;

    localparam logic [3:0] VSEL_NONE  = 4'b0000;
    localparam logic [3:0] VSEL_C     = 4'b0001;
    localparam logic [3:0] VSEL_PC    = 4'b0010;
    localparam logic [3:0] VSEL_IMM   = 4'b0100;
    localparam logic [3:0] VSEL_MDATA = 4'b1000;

    function automatic logic is_legal(input logic [2:0] opcode, input logic [1:0] op);
        return (opcode == OPC_ALU) ||
               ((opcode == OPC_MOV) && ((op == OP_MOV_REG) || (op == OP_MOV_IMM)));
    endfunction

endpackage

// File: rtl/cpu_fsm.sv
// Moore controller stepping the register-file/ALU datapath through one instruction;
// {opcode,op} is captured when leaving WAIT and drives all later routing.
module cpu_fsm
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic       w,
    output logic [2:0] nsel,
    output logic [3:0] vsel,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       asel,
    output logic       bsel,
    output logic       write,
    output logic       illegal
);

    state_t     state_q, state_d;
    logic [2:0] opc_q, opc_d;
    logic [1:0] op_q, op_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StWait;
            opc_q   <= 3'b000;
            op_q    <= 2'b00;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
            op_q    <= op_d;
        end
    end

    // Instruction fields are only captured on the WAIT->DECODE edge.
    always_comb begin
        opc_d = opc_q;
        op_d  = op_q;
        if ((state_q == StWait) && s) begin
            opc_d = opcode;
            op_d  = op;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StWait: begin
                if (s) state_d = StDecode;
            end
            StDecode: begin
                if (!is_legal(opc_q, op_q)) begin
                    state_d = StWait;
                end else if (opc_q == OPC_MOV) begin
                    state_d = (op_q == OP_MOV_IMM) ? StWriteImm : StGetB;
                end else begin
                    state_d = (op_q == OP_MVN) ? StGetB : StGetA;
                end
            end
            StWriteImm: state_d = StWait;
            StGetA:     state_d = StGetB;
            StGetB:     state_d = StAlu;
            StAlu: begin
                if ((opc_q == OPC_ALU) && (op_q == OP_CMP)) state_d = StWait;
                else                                       state_d = StWriteReg;
            end
            StWriteReg: state_d = StWait;
            default:    state_d = StWait;
        endcase
    end

    always_comb begin
        w       = 1'b0;
        nsel    = NSEL_NONE;
        vsel    = VSEL_NONE;
        loada   = 1'b0;
        loadb   = 1'b0;
        loadc   = 1'b0;
        loads   = 1'b0;
        asel    = 1'b0;
        bsel    = 1'b0;
        write   = 1'b0;
        illegal = 1'b0;
        unique case (state_q)
            StWait: w = 1'b1;
            StDecode: illegal = !is_legal(opc_q, op_q);
            StWriteImm: begin
                nsel  = NSEL_RN;
                vsel  = VSEL_IMM;
                write = 1'b1;
            end
            StGetA: begin
                nsel  = NSEL_RN;
                loada = 1'b1;
            end
            StGetB: begin
                nsel  = NSEL_RM;
                loadb = 1'b1;
            end
            StAlu: begin
                // MOV reg reuses the ADD path with A forced to zero.
                asel = ((opc_q == OPC_MOV) && (op_q == OP_MOV_REG)) ||
                       ((opc_q == OPC_ALU) && (op_q == OP_MVN));
                if ((opc_q == OPC_ALU) && (op_q == OP_CMP)) loads = 1'b1;
                else                                       loadc = 1'b1;
            end
            StWriteReg: begin
                nsel  = NSEL_RD;
                vsel  = VSEL_C;
                write = 1'b1;
            end
            default: w = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_cpu_fsm.sv
// Self-checking bench: per-instruction expected output sequences drawn from a
// table model, with directed cases followed by randomized instruction streams.
module tb_cpu_fsm;

    logic       clk;
    logic       rst_n;
    logic       s;
    logic [2:0] opcode;
    logic [1:0] op;
    logic       w;
    logic [2:0] nsel;
    logic [3:0] vsel;
    logic       loada, loadb, loadc, loads, asel, bsel, write, illegal;

    int n_checks = 0;
    int n_fails  = 0;

    cpu_fsm dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s       (s),
        .opcode  (opcode),
        .op      (op),
        .w       (w),
        .nsel    (nsel),
        .vsel    (vsel),
        .loada   (loada),
        .loadb   (loadb),
        .loadc   (loadc),
        .loads   (loads),
        .asel    (asel),
        .bsel    (bsel),
        .write   (write),
        .illegal (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view: {w, nsel, vsel, loada, loadb, loadc, loads, asel, bsel, write, illegal}
    logic [15:0] outs;
    assign outs = {w, nsel, vsel, loada, loadb, loadc, loads, asel, bsel, write, illegal};

    localparam logic [15:0] V_WAIT    = 16'h8000;
    localparam logic [15:0] V_DECODE  = 16'h0000;
    localparam logic [15:0] V_ILLEGAL = 16'h0001;
    localparam logic [15:0] V_WR_IMM  = 16'h1402;
    localparam logic [15:0] V_GET_A   = 16'h1080;
    localparam logic [15:0] V_GET_B   = 16'h4040;
    localparam logic [15:0] V_ALU_C   = 16'h0020;
    localparam logic [15:0] V_ALU_CA  = 16'h0028;
    localparam logic [15:0] V_ALU_S   = 16'h0010;
    localparam logic [15:0] V_WR_REG  = 16'h2102;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected per-cycle outputs while w=0, written straight from the instruction table.
    task automatic expected_seq(input logic [2:0] opc, input logic [1:0] o,
                                output logic [15:0] seq [$]);
        seq.delete();
        case ({opc, o})
            5'b110_10: seq = '{V_DECODE, V_WR_IMM};
            5'b110_00: seq = '{V_DECODE, V_GET_B, V_ALU_CA, V_WR_REG};
            5'b101_00: seq = '{V_DECODE, V_GET_A, V_GET_B, V_ALU_C, V_WR_REG};
            5'b101_10: seq = '{V_DECODE, V_GET_A, V_GET_B, V_ALU_C, V_WR_REG};
            5'b101_01: seq = '{V_DECODE, V_GET_A, V_GET_B, V_ALU_S};
            5'b101_11: seq = '{V_DECODE, V_GET_B, V_ALU_CA, V_WR_REG};
            default:   seq = '{V_ILLEGAL};
        endcase
    endtask

    // Runs one instruction from WAIT; rst_at >= 0 pulls reset during that cycle index.
    task automatic run_instr(input logic [2:0] opc, input logic [1:0] o,
                             input bit scramble, input int rst_at);
        logic [15:0] seq [$];
        logic [15:0] nload;
        expected_seq(opc, o, seq);
        check_eq("wait_before", outs, V_WAIT);
        s      = 1'b1;
        opcode = opc;
        op     = o;
        step();
        for (int i = 0; i < seq.size(); i++) begin
            check_eq($sformatf("seq_%b_%b_%0d", opc, o, i), outs, seq[i]);
            nload = 16'($countones({loada, loadb, loadc, loads, write}));
            check_eq("load_excl", (nload <= 16'd1) ? 16'd1 : 16'd0, 16'd1);
            s = 1'b0;
            if (scramble) begin
                opcode = 3'($urandom);
                op     = 2'($urandom);
                s      = 1'($urandom);
            end
            if (i == rst_at) rst_n = 1'b0;
            step();
            if (i == rst_at) begin
                check_eq("rst_abort", outs, V_WAIT);
                rst_n = 1'b1;
                s     = 1'b0;
                return;
            end
        end
        check_eq("wait_after", outs, V_WAIT);
        s = 1'b0;
    endtask

    logic [2:0] legal_opc [6] = '{3'b110, 3'b110, 3'b101, 3'b101, 3'b101, 3'b101};
    logic [1:0] legal_op  [6] = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b10, 2'b11};

    initial begin
        logic [15:0] seq [$];
        int          k;
        int          r;
        rst_n  = 1'b0;
        s      = 1'b1;
        opcode = 3'b110;
        op     = 2'b10;
        step();
        check_eq("reset_1", outs, V_WAIT);
        step();
        check_eq("reset_2", outs, V_WAIT);
        rst_n = 1'b1;
        s     = 1'b0;
        step();
        check_eq("idle_wait", outs, V_WAIT);

        run_instr(3'b110, 2'b10, 1'b0, -1);   // MOV imm
        run_instr(3'b101, 2'b00, 1'b0, -1);   // ADD
        run_instr(3'b101, 2'b01, 1'b0, -1);   // CMP
        run_instr(3'b101, 2'b11, 1'b1, -1);   // MVN, inputs disturbed mid-instruction
        run_instr(3'b110, 2'b00, 1'b1, -1);   // MOV reg, inputs disturbed
        run_instr(3'b111, 2'b00, 1'b0, -1);   // illegal
        run_instr(3'b101, 2'b00, 1'b0, 2);    // ADD aborted in GET_B

        // Back-to-back with s held: WAIT for exactly one cycle between instructions.
        run_instr(3'b101, 2'b10, 1'b0, -1);
        s      = 1'b1;
        opcode = 3'b110;
        op     = 2'b10;
        step();
        check_eq("b2b_decode", outs, V_DECODE);
        step();
        check_eq("b2b_wrimm", outs, V_WR_IMM);
        s = 1'b0;
        step();
        check_eq("b2b_wait", outs, V_WAIT);

        for (int n = 0; n < 300; n++) begin
            logic [2:0] ropc;
            logic [1:0] rop;
            if ($urandom_range(0, 9) < 7) begin
                k    = $urandom_range(0, 5);
                ropc = legal_opc[k];
                rop  = legal_op[k];
            end else begin
                ropc = 3'($urandom);
                rop  = 2'($urandom);
            end
            expected_seq(ropc, rop, seq);
            r = ($urandom_range(0, 9) == 0) ? $urandom_range(0, seq.size() - 1) : -1;
            run_instr(ropc, rop, 1'($urandom), r);
            k = $urandom_range(0, 2);
            for (int j = 0; j < k; j++) begin
                opcode = 3'($urandom);
                op     = 2'($urandom);
                step();
                check_eq("idle", outs, V_WAIT);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
